// File: rtl/nn_mac_sequencer.sv
// Sequencer for a 2-2-1 neural network forward pass on one shared external MAC unit.
// It snapshots the operands at start, then issues six MAC operations and applies ReLU to the hidden neurons.
module nn_mac_sequencer #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64,
   parameter bit RELU_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              start,
   input  logic [DATA_W-1:0] opA,
   input  logic [DATA_W-1:0] opB,
   input  logic [DATA_W-1:0] w11,
   input  logic [DATA_W-1:0] w12,
   input  logic [DATA_W-1:0] w21,
   input  logic [DATA_W-1:0] w22,
   input  logic [DATA_W-1:0] b1,
   input  logic [DATA_W-1:0] b2,
   input  logic [DATA_W-1:0] w31,
   input  logic [DATA_W-1:0] w32,
   input  logic [DATA_W-1:0] b3,
   output logic              mac_valid,
   input  logic              mac_ready,
   output logic [DATA_W-1:0] mac_a,
   output logic [DATA_W-1:0] mac_b,
   output logic [DATA_W-1:0] mac_c,
   input  logic              mac_rvalid,
   input  logic [DATA_W-1:0] mac_res,
   output logic [DATA_W-1:0] NN_result,
   output logic              ready,
   output logic              busy,
   output logic              err
);

   localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        step_q, step_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] h1_q, h1_d;
   logic [DATA_W-1:0] h2_q, h2_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              err_q, err_d;
   logic              snap_ld;

   logic [DATA_W-1:0] opa_q, opb_q, w11_q, w12_q, w21_q, w22_q;
   logic [DATA_W-1:0] b1_q, b2_q, w31_q, w32_q, b3_q;

   // Sign test only; the MAC does all arithmetic.
   function automatic logic [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
      if (RELU_EN && (v < 0)) return '0;
      return v;
   endfunction

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         opa_q <= '0;
         opb_q <= '0;
         w11_q <= '0;
         w12_q <= '0;
         w21_q <= '0;
         w22_q <= '0;
         b1_q  <= '0;
         b2_q  <= '0;
         w31_q <= '0;
         w32_q <= '0;
         b3_q  <= '0;
      end else if (snap_ld) begin
         opa_q <= opA;
         opb_q <= opB;
         w11_q <= w11;
         w12_q <= w12;
         w21_q <= w21;
         w22_q <= w22;
         b1_q  <= b1;
         b2_q  <= b2;
         w31_q <= w31;
         w32_q <= w32;
         b3_q  <= b3;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q  <= IDLE;
         step_q   <= '0;
         wdog_q   <= '0;
         acc_q    <= '0;
         h1_q     <= '0;
         h2_q     <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         wdog_q   <= wdog_d;
         acc_q    <= acc_d;
         h1_q     <= h1_d;
         h2_q     <= h2_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      wdog_d    = wdog_q;
      acc_d     = acc_q;
      h1_d      = h1_q;
      h2_d      = h2_q;
      result_d  = result_q;
      err_d     = 1'b0;
      snap_ld   = 1'b0;
      mac_valid = 1'b0;
      ready     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               snap_ld = 1'b1;
               step_d  = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            mac_valid = 1'b1;
            if (mac_ready) begin
               wdog_d  = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (mac_rvalid) begin
               acc_d = mac_res;
               case (step_q)
                  3'd1:    h1_d     = relu(mac_res);
                  3'd3:    h2_d     = relu(mac_res);
                  3'd5:    result_d = mac_res;
                  default: ;
               endcase
               if (step_q == 3'd5) begin
                  state_d = DONE;
               end else begin
                  step_d  = step_q + 3'd1;
                  state_d = ISSUE;
               end
            end else if (wdog_q == WD_LAST) begin
               // Abort leaves NN_result untouched; err shows in the first IDLE cycle.
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         DONE: begin
            ready   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operands depend only on step and registers, so they stay stable through a ready stall.
   always_comb begin
      mac_a = '0;
      mac_b = '0;
      mac_c = '0;
      case (step_q)
         3'd0: begin mac_a = w11_q; mac_b = opa_q; mac_c = b1_q;  end
         3'd1: begin mac_a = w12_q; mac_b = opb_q; mac_c = acc_q; end
         3'd2: begin mac_a = w21_q; mac_b = opa_q; mac_c = b2_q;  end
         3'd3: begin mac_a = w22_q; mac_b = opb_q; mac_c = acc_q; end
         3'd4: begin mac_a = w31_q; mac_b = h1_q;  mac_c = b3_q;  end
         3'd5: begin mac_a = w32_q; mac_b = h2_q;  mac_c = acc_q; end
         default: ;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign err       = err_q;
   assign NN_result = result_q;

endmodule

// File: tb/tb_nn_mac_sequencer.sv
// Scoreboard bench for nn_mac_sequencer: two instances (ReLU on and off) with their own MAC models, checked against a forward-pass reference.
module tb_nn_mac_sequencer;
   localparam int DW = 32;
   localparam int TO = 64;
   localparam int L  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_l, start, mac_ready;
   logic [DW-1:0] opA, opB, w11, w12, w21, w22, b1, b2, w31, w32, b3;
   logic          mac_valid_w [2];
   logic          mac_rvalid_w[2];
   logic          ready_w     [2];
   logic          busy_w      [2];
   logic          err_w       [2];
   logic [DW-1:0] mac_a_w     [2];
   logic [DW-1:0] mac_b_w     [2];
   logic [DW-1:0] mac_c_w     [2];
   logic [DW-1:0] mac_res_w   [2];
   logic [DW-1:0] nn_res_w    [2];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   bit hang_en = 1'b0;
   int rmode = 0;
   int stall_left = 0;

   typedef struct {
      bit          is_err;
      logic [31:0] val;
      int          cyc;
   } exp_t;
   exp_t q0[$];
   exp_t q1[$];
   logic [31:0] last_y[2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      nn_mac_sequencer #(.DATA_W(DW), .TIMEOUT(TO), .RELU_EN(g == 0)) u_dut (
         .clk        (clk),
         .rst_l      (rst_l),
         .start      (start),
         .opA        (opA),
         .opB        (opB),
         .w11        (w11),
         .w12        (w12),
         .w21        (w21),
         .w22        (w22),
         .b1         (b1),
         .b2         (b2),
         .w31        (w31),
         .w32        (w32),
         .b3         (b3),
         .mac_valid  (mac_valid_w[g]),
         .mac_ready  (mac_ready),
         .mac_a      (mac_a_w[g]),
         .mac_b      (mac_b_w[g]),
         .mac_c      (mac_c_w[g]),
         .mac_rvalid (mac_rvalid_w[g]),
         .mac_res    (mac_res_w[g]),
         .NN_result  (nn_res_w[g]),
         .ready      (ready_w[g]),
         .busy       (busy_w[g]),
         .err        (err_w[g])
      );

      // MAC model: result = c + a*b mod 2^32, returned exactly L=2 cycles after the handshake.
      logic        p0_v, p1_v;
      logic [31:0] p0_d, p1_d;
      int          op_cnt;
      always @(posedge clk or negedge rst_l) begin
         if (!rst_l) begin
            p0_v   <= 1'b0;
            p1_v   <= 1'b0;
            p0_d   <= '0;
            p1_d   <= '0;
            op_cnt <= 0;
         end else begin
            p1_v <= p0_v;
            p1_d <= p0_d;
            p0_v <= 1'b0;
            if (start && !busy_w[g]) begin
               op_cnt <= 0;
            end else if (mac_valid_w[g] && mac_ready) begin
               op_cnt <= op_cnt + 1;
               p0_v   <= !(hang_en && op_cnt == 4);
               p0_d   <= mac_c_w[g] + mac_a_w[g] * mac_b_w[g];
            end
         end
      end
      assign mac_rvalid_w[g] = p1_v;
      assign mac_res_w[g]    = p1_d;
   end

   function automatic logic [31:0] ref_y(input bit relu_on);
      logic [31:0] h1, h2;
      h1 = b1 + w11 * opA + w12 * opB;
      h2 = b2 + w21 * opA + w22 * opB;
      if (relu_on && $signed(h1) < 0) h1 = '0;
      if (relu_on && $signed(h2) < 0) h2 = '0;
      return b3 + w31 * h1 + w32 * h2;
   endfunction

   task automatic push_exp(input int g, input exp_t e);
      if (g == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic pop_exp(input int g, output exp_t e, output bit got);
      got = 1'b0;
      e   = '{1'b0, 32'h0, -1};
      if (g == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      if (g == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
   endtask

   task automatic push_pass(input int s, input bit timed, input int extra);
      exp_t e;
      for (int g = 0; g < 2; g++) begin
         e.is_err  = 1'b0;
         e.val     = ref_y(g == 0);
         e.cyc     = timed ? s + 6 * (1 + L) + 1 + extra : -1;
         last_y[g] = e.val;
         push_exp(g, e);
      end
   endtask

   task automatic push_err(input int s);
      exp_t e;
      for (int g = 0; g < 2; g++) begin
         e.is_err = 1'b1;
         e.val    = last_y[g];
         e.cyc    = s + 4 * (1 + L) + 1 + TO + 1;
         push_exp(g, e);
      end
   endtask

   task automatic start_pass(input int mode, input int extra, output int s);
      s     = cyc;
      start = 1'b1;
      if (mode == 1) push_pass(s, 1'b1, extra);
      if (mode == 2) push_pass(s, 1'b0, 0);
      if (mode == 3) push_err(s);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      while ((busy_w[0] || busy_w[1]) && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("idle_bound", 32'(n >= bound), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic set_base();
      opA = 32'd3;          opB = 32'd4;
      w11 = 32'd1;          w12 = 32'd2;          b1 = 32'd1;
      w21 = 32'hFFFF_FFFF;  w22 = 32'd1;          b2 = 32'hFFFF_FFFB;
      w31 = 32'd2;          w32 = 32'd7;          b3 = 32'd10;
   endtask

   task automatic check_zero(input int g, input string tag);
      check({tag, "_result"}, nn_res_w[g], 32'd0);
      check({tag, "_ready"}, 32'(ready_w[g]), 32'd0);
      check({tag, "_busy"}, 32'(busy_w[g]), 32'd0);
      check({tag, "_err"}, 32'(err_w[g]), 32'd0);
      check({tag, "_mvalid"}, 32'(mac_valid_w[g]), 32'd0);
      check({tag, "_mac_a"}, mac_a_w[g], 32'd0);
      check({tag, "_mac_b"}, mac_b_w[g], 32'd0);
      check({tag, "_mac_c"}, mac_c_w[g], 32'd0);
   endtask

   // mac_ready driver: always ready, random, or a 5-cycle stall on step 2 with operand checks.
   always @(negedge clk) begin
      case (rmode)
         1: mac_ready = ($urandom_range(3) != 0);
         2: begin
            if (stall_left > 0 && g_dut[0].op_cnt == 2 && mac_valid_w[0]) begin
               mac_ready = 1'b0;
               stall_left--;
               check("stall_mac_a", mac_a_w[0], w21);
               check("stall_mac_b", mac_b_w[0], opA);
               check("stall_mac_c", mac_c_w[0], b2);
            end else begin
               mac_ready = 1'b1;
            end
         end
         default: mac_ready = 1'b1;
      endcase
   end

   // Monitor: every ready/err pulse is matched against the oldest expected response.
   always @(negedge clk) begin
      if (rst_l) begin
         for (int g = 0; g < 2; g++) begin
            if (ready_w[g] || err_w[g]) begin
               exp_t e;
               bit   got;
               pop_exp(g, e, got);
               if (!got) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_resp dut%0d: got ready=%0d err=%0d, required no response", g, ready_w[g], err_w[g]);
               end else begin
                  check($sformatf("kind_dut%0d", g), 32'(err_w[g]), 32'(e.is_err));
                  check($sformatf("result_dut%0d", g), nn_res_w[g], e.val);
                  if (e.cyc >= 0) check($sformatf("cycle_dut%0d", g), 32'(cyc), 32'(e.cyc));
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
      $fatal(1, "global timeout");
   end

   initial begin
      int s, s2;
      rst_l = 1'b0;
      start = 1'b0;
      mac_ready = 1'b1;
      set_base();
      last_y[0] = '0;
      last_y[1] = '0;
      repeat (3) @(negedge clk);
      check_zero(0, "rst0");
      check_zero(1, "rst1");
      rst_l = 1'b1;
      repeat (2) @(negedge clk);

      // Reference pass: 34 with ReLU, 6 without; busy window s+1..s+19.
      check("busy_before", 32'(busy_w[0]), 32'd0);
      start_pass(1, 0, s);
      check("busy_s1", 32'(busy_w[0]), 32'd1);
      repeat (18) @(negedge clk);
      check("busy_s19", 32'(busy_w[0]), 32'd1);
      check("ready_s19", 32'(ready_w[0]), 32'd1);
      @(negedge clk);
      check("busy_s20", 32'(busy_w[0]), 32'd0);
      check("ready_s20", 32'(ready_w[0]), 32'd0);
      wait_idle(100);

      // Five-cycle mac_ready stall at step 2.
      rmode = 2;
      stall_left = 5;
      start_pass(1, 5, s);
      wait_idle(100);
      check("stall_consumed", 32'(stall_left), 32'd0);
      rmode = 0;
      mac_ready = 1'b1;
      @(negedge clk);

      // Mid-pass start and opA write ignored; start in DONE ignored, next cycle accepted.
      start_pass(1, 0, s);
      repeat (6) @(negedge clk);
      start = 1'b1;
      opA = 32'd100;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      s2 = cyc;
      push_pass(s2, 1'b1, 0);
      @(negedge clk);
      start = 1'b0;
      wait_idle(100);

      // MAC never answers step 4: watchdog abort with result held.
      set_base();
      hang_en = 1'b1;
      start_pass(3, 0, s);
      wait_idle(200);
      hang_en = 1'b0;
      check("busy_after_err", 32'(busy_w[0]), 32'd0);
      check("result_after_err", nn_res_w[0], last_y[0]);

      // Asynchronous reset during WAIT of step 3, then a clean pass.
      start_pass(0, 0, s);
      repeat (10) @(negedge clk);
      rst_l = 1'b0;
      #1;
      check_zero(0, "midrst0");
      check("midrst1_busy", 32'(busy_w[1]), 32'd0);
      check("midrst1_result", nn_res_w[1], 32'd0);
      last_y[0] = '0;
      last_y[1] = '0;
      @(negedge clk);
      rst_l = 1'b1;
      @(negedge clk);
      start_pass(1, 0, s);
      wait_idle(100);

      // Randomized passes, alternating always-ready (timed) and random back-pressure.
      for (int i = 0; i < 12; i++) begin
         if (i % 3 == 0) begin
            opA = $urandom; opB = $urandom; w11 = $urandom; w12 = $urandom;
            w21 = $urandom; w22 = $urandom; b1 = $urandom; b2 = $urandom;
            w31 = $urandom; w32 = $urandom; b3 = $urandom;
         end else begin
            opA = $urandom_range(20) - 10; opB = $urandom_range(20) - 10;
            w11 = $urandom_range(20) - 10; w12 = $urandom_range(20) - 10;
            w21 = $urandom_range(20) - 10; w22 = $urandom_range(20) - 10;
            b1  = $urandom_range(20) - 10; b2  = $urandom_range(20) - 10;
            w31 = $urandom_range(20) - 10; w32 = $urandom_range(20) - 10;
            b3  = $urandom_range(20) - 10;
         end
         if (i % 2 == 0) begin
            rmode = 0;
            mac_ready = 1'b1;
            start_pass(1, 0, s);
         end else begin
            rmode = 1;
            start_pass(2, 0, s);
         end
         wait_idle(300);
      end
      rmode = 0;
      mac_ready = 1'b1;
      repeat (5) @(negedge clk);

      check("sb_empty_dut0", 32'(q0.size()), 32'd0);
      check("sb_empty_dut1", 32'(q1.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
